bcd_digit_scanner: RTL and testbench

Four-digit BCD event counter with a time-multiplexed display scanner. It sits directly upstream of the per-segment seven-segment decoders. Each cycle it drives one BCD digit on `numeral_bit[3:0]`, which the segment decoders consume combinationally, together with the matching active-low digit enable for a common-anode display. Counting, display freeze, leading-zero blanking and refresh timing all live here; the downstream decoders stay purely combinational.

---
 rtl/bcd_digit_scanner_if.sv | 28 ++
 rtl/bcd_digit_scanner.sv | 129 ++++++++++++
 tb/tb_bcd_digit_scanner.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_scanner_if.sv
// Bus between the BCD scanner and its user: count controls in,
// scanned digit, active-low digit enable and wrap pulse out.
interface bcd_digit_scanner_if;
    logic       clear;
    logic       inc;
    logic       hold;
    logic [3:0] numeral_bit;
    logic [3:0] digit_enable_n;
    logic       overflow;

    modport master (
        output clear,
        output inc,
        output hold,
        input  numeral_bit,
        input  digit_enable_n,
        input  overflow
    );

    modport slave (
        input  clear,
        input  inc,
        input  hold,
        output numeral_bit,
        output digit_enable_n,
        output overflow
    );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Four-digit BCD event counter with a frozen-able display copy and a
// time-multiplexed, leading-zero-blanked scanner for a common-anode display.
module bcd_digit_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_digit_scanner_if.slave   bus
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    // {carry_out, digit} for one decimal digit with carry in
    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic cin);
        logic [4:0] r;
        if (!cin) begin
            r = {1'b0, d};
        end else if (d == 4'd9) begin
            r = {1'b1, 4'd0};
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

    logic [3:0][3:0] cnt_q, cnt_d;
    logic [3:0][3:0] disp_q, disp_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      num_q, num_d;
    logic [3:0]      en_n_q, en_n_d;
    logic            ovf_q, ovf_d;

    logic            carry_s;
    logic [4:0]      step_s;
    logic [3:0]      dz_s;
    logic [3:0]      zero_above_s;
    logic            blank_s;

    // Counter next state: ripple the increment through the digits, clear wins
    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        carry_s = bus.inc;
        step_s  = 5'd0;
        for (int k = 0; k < 4; k++) begin
            step_s   = bcd_inc(cnt_q[k], carry_s);
            cnt_d[k] = step_s[3:0];
            carry_s  = step_s[4];
        end
        if (bus.clear) begin
            cnt_d = 16'h0000;
            ovf_d = 1'b0;
        end else begin
            ovf_d = carry_s;
        end
    end

    // Display copy and scan timing
    always_comb begin
        disp_d = disp_q;
        pre_d  = pre_q;
        idx_d  = idx_q;
        if (!bus.hold) begin
            disp_d = cnt_q;
        end else begin
            disp_d = disp_q;
        end
        if (pre_q == PRE_LAST) begin
            pre_d = {PW{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            pre_d = pre_q + PW'(1);
            idx_d = idx_q;
        end
    end

    // zero_above_s[k]: digit k and every more significant digit are zero
    assign dz_s = {disp_q[3] == 4'd0, disp_q[2] == 4'd0,
                   disp_q[1] == 4'd0, disp_q[0] == 4'd0};
    assign zero_above_s = {dz_s[3], &dz_s[3:2], &dz_s[3:1], &dz_s[3:0]};
    assign blank_s = (idx_q != 2'd0) && zero_above_s[idx_q];

    // Output register next state for the selected digit
    always_comb begin
        num_d  = disp_q[idx_q];
        en_n_d = 4'b1111;
        case (idx_q)
            2'd0:    en_n_d = 4'b1110;
            2'd1:    en_n_d = 4'b1101;
            2'd2:    en_n_d = 4'b1011;
            2'd3:    en_n_d = 4'b0111;
            default: en_n_d = 4'b1111;
        endcase
        if (blank_s) begin
            num_d  = 4'd0;
            en_n_d = 4'b1111;
        end else begin
            num_d  = disp_q[idx_q];
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 16'h0000;
            disp_q <= 16'h0000;
            pre_q  <= {PW{1'b0}};
            idx_q  <= 2'd0;
            num_q  <= 4'd0;
            en_n_q <= 4'b1110;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            num_q  <= num_d;
            en_n_q <= en_n_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.numeral_bit    = num_q;
    assign bus.digit_enable_n = en_n_q;
    assign bus.overflow       = ovf_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner with REFRESH_DIV=4: reset, counting,
// wrap, blanking, hold and clear priority against hand-computed values.
module tb_bcd_digit_scanner;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    bcd_digit_scanner_if bus();

    bcd_digit_scanner #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output shown after edge n (counted from reset release) belongs to this digit
    function automatic int out_idx(input int n);
        return (n == 0) ? 0 : ((n - 1) / 4) % 4;
    endfunction

    function automatic int sig_digits(input logic [15:0] v);
        int nd = 1;
        for (int k = 0; k < 4; k++) begin
            if (v[4*k +: 4] != 4'd0) nd = k + 1;
        end
        return nd;
    endfunction

    // One full frame, every cycle compared
    task automatic check_scan(input logic [15:0] v, input string tag);
        int         k;
        logic [3:0] one;
        logic [3:0] exp_num;
        logic [3:0] exp_en;
        one = 4'b0001;
        repeat (16) begin
            tick();
            k = out_idx(cyc);
            if (k < sig_digits(v)) begin
                exp_num = v[4*k +: 4];
                exp_en  = ~(one << k);
            end else begin
                exp_num = 4'd0;
                exp_en  = 4'b1111;
            end
            chk({tag, "_num"}, {4'd0, bus.numeral_bit}, {4'd0, exp_num});
            chk({tag, "_en"},  {4'd0, bus.digit_enable_n}, {4'd0, exp_en});
        end
    endtask

    task automatic align(input int m);
        repeat (16) begin
            if (cyc % 16 != m) tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.clear = 1'b0;
        bus.inc   = 1'b0;
        bus.hold  = 1'b0;
        #22;
        chk("rst0_num", {4'd0, bus.numeral_bit}, 8'h00);
        chk("rst0_en",  {4'd0, bus.digit_enable_n}, 8'h0E);
        chk("rst0_ovf", {7'd0, bus.overflow}, 8'h00);
        reset = 1'b0;
        cyc   = 0;
        check_scan(16'h0000, "init");

        // count to 1234 with the last increment landing on a digit-0 slot
        align(14);
        bus.inc = 1'b1;
        repeat (1234) tick();
        bus.inc = 1'b0;
        tick();
        chk("lat_e1_num", {4'd0, bus.numeral_bit}, 8'h03);
        chk("lat_e1_en",  {4'd0, bus.digit_enable_n}, 8'h0E);
        tick();
        chk("lat_e2_num", {4'd0, bus.numeral_bit}, 8'h04);
        check_scan(16'h1234, "c1234");

        // asynchronous reset mid-frame
        reset = 1'b1;
        #1;
        chk("rst1_num", {4'd0, bus.numeral_bit}, 8'h00);
        chk("rst1_en",  {4'd0, bus.digit_enable_n}, 8'h0E);
        chk("rst1_ovf", {7'd0, bus.overflow}, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        check_scan(16'h0000, "postrst");
        bus.inc = 1'b1;
        tick();
        bus.inc = 1'b0;
        tick();
        check_scan(16'h0001, "first_inc");

        // wrap 9999 -> 0000
        bus.inc = 1'b1;
        repeat (9997) tick();
        chk("ovf_9998", {7'd0, bus.overflow}, 8'h00);
        tick();
        chk("ovf_9999", {7'd0, bus.overflow}, 8'h00);
        tick();
        chk("ovf_wrap", {7'd0, bus.overflow}, 8'h01);
        bus.inc = 1'b0;
        tick();
        chk("ovf_after", {7'd0, bus.overflow}, 8'h00);
        check_scan(16'h0000, "wrapped");

        // leading-zero blanking
        bus.inc = 1'b1;
        repeat (70) tick();
        bus.inc = 1'b0;
        tick();
        check_scan(16'h0070, "c0070");
        bus.inc = 1'b1;
        repeat (935) tick();
        bus.inc = 1'b0;
        tick();
        check_scan(16'h1005, "c1005");

        // hold freezes display while counting continues
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_ovf", {7'd0, bus.overflow}, 8'h00);
        bus.inc = 1'b1;
        repeat (42) tick();
        bus.inc = 1'b0;
        tick();
        check_scan(16'h0042, "c0042");
        bus.hold = 1'b1;
        bus.inc  = 1'b1;
        repeat (10) tick();
        bus.inc = 1'b0;
        tick();
        check_scan(16'h0042, "held");
        bus.hold = 1'b0;
        tick();
        check_scan(16'h0052, "released");

        // clear beats inc at 9999, display held
        bus.inc = 1'b1;
        repeat (9947) tick();
        bus.inc = 1'b0;
        tick();
        check_scan(16'h9999, "c9999");
        bus.hold  = 1'b1;
        bus.clear = 1'b1;
        bus.inc   = 1'b1;
        tick();
        chk("clrinc_ovf", {7'd0, bus.overflow}, 8'h00);
        bus.clear = 1'b0;
        bus.inc   = 1'b0;
        tick();
        chk("clrinc_ovf2", {7'd0, bus.overflow}, 8'h00);
        check_scan(16'h9999, "hold_clr");
        bus.hold = 1'b0;
        tick();
        check_scan(16'h0000, "cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
